// File: rtl/filter_mul_pkg.sv
// Shared constants and saturation limits for the filter multiplier.
// Latency: none (package only).
// Backpressure: not applicable.
package filter_mul_pkg;

    localparam int ACC_GUARD     = 8;
    localparam int NUM_STAGE_MIN = 1;
    localparam int NUM_STAGE_MAX = 8;
    // Wide enough for the largest accumulator (32+32+8) plus sign headroom.
    localparam int SAT_W         = 80;

    function automatic logic signed [SAT_W-1:0] sat_limit(
        input int   width,
        input logic is_signed,
        input logic upper
    );
        logic signed [SAT_W-1:0] one;
        one = {{(SAT_W-1){1'b0}}, 1'b1};
        if (is_signed) begin
            if (upper) return (one <<< (width - 1)) - one;
            return -(one <<< (width - 1));
        end
        if (upper) return (one <<< width) - one;
        return '0;
    endfunction

endpackage

// File: rtl/filter_mul_pipe_core.sv
// Full-width multiplier with a valid/last-tagged register pipeline.
// Latency: NUM_STAGE cycles from accepted operands to prod_dat.
// Backpressure: every stage holds while en is low.
module filter_mul_pipe_core
    import filter_mul_pkg::*;
#(
    parameter int A_W       = 8,
    parameter int B_W       = 22,
    parameter int A_SIGNED  = 0,
    parameter int B_SIGNED  = 0,
    parameter int NUM_STAGE = 3
) (
    input  logic               core_clk,
    input  logic               arst_n,
    input  logic               en,
    input  logic               in_vld,
    input  logic               in_last,
    input  logic [A_W-1:0]     a_dat,
    input  logic [B_W-1:0]     b_dat,
    output logic               out_vld,
    output logic               out_last,
    output logic [A_W+B_W-1:0] prod_dat,
    output logic               any_vld
);
    localparam int P_W = A_W + B_W;

    logic [P_W-1:0]       a_ext;
    logic [P_W-1:0]       b_ext;
    logic [P_W-1:0]       prod_now;
    logic [P_W-1:0]       prod_q [NUM_STAGE];
    logic [NUM_STAGE-1:0] vld_q;
    logic [NUM_STAGE-1:0] last_q;

    // Extending both operands to the product width makes a plain modular
    // multiply correct for any mix of signed and unsigned operands.
    assign a_ext    = {{B_W{(A_SIGNED != 0) && a_dat[A_W-1]}}, a_dat};
    assign b_ext    = {{A_W{(B_SIGNED != 0) && b_dat[B_W-1]}}, b_dat};
    assign prod_now = a_ext * b_ext;

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            vld_q  <= '0;
            last_q <= '0;
            for (int i = 0; i < NUM_STAGE; i++) prod_q[i] <= '0;
        end else if (en) begin
            vld_q[0]  <= in_vld;
            last_q[0] <= in_vld && in_last;
            prod_q[0] <= prod_now;
            for (int i = 1; i < NUM_STAGE; i++) begin
                vld_q[i]  <= vld_q[i-1];
                last_q[i] <= last_q[i-1];
                prod_q[i] <= prod_q[i-1];
            end
        end
    end

    assign out_vld  = vld_q[NUM_STAGE-1];
    assign out_last = last_q[NUM_STAGE-1];
    assign prod_dat = prod_q[NUM_STAGE-1];
    assign any_vld  = |vld_q;

endmodule

// File: rtl/filter_mul_pipe.sv
// Pipelined multiplier / multiply-accumulator with truncate or saturate output.
// Latency: NUM_STAGE cycles (NUM_STAGE+1 after din_last in accumulate mode).
// Backpressure: whole pipeline stalls while dout_valid && !dout_ready; din_ready mirrors advance.
module filter_mul_pipe
    import filter_mul_pkg::*;
#(
    parameter int DIN0_WIDTH  = 8,
    parameter int DIN1_WIDTH  = 22,
    parameter int DOUT_WIDTH  = 29,
    parameter int NUM_STAGE   = 3,
    parameter int DIN0_SIGNED = 0,
    parameter int DIN1_SIGNED = 0,
    parameter int SATURATE    = 0,
    parameter int ACC_EN      = 0
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic [DIN0_WIDTH-1:0] din0,
    input  logic [DIN1_WIDTH-1:0] din1,
    input  logic                  din_last,
    input  logic                  din_valid,
    output logic                  din_ready,
    output logic [DOUT_WIDTH-1:0] dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  busy
);
    localparam int   P_W      = DIN0_WIDTH + DIN1_WIDTH;
    localparam int   ACC_W    = P_W + ACC_GUARD;
    localparam int   NS       = (NUM_STAGE < NUM_STAGE_MIN) ? NUM_STAGE_MIN :
                                (NUM_STAGE > NUM_STAGE_MAX) ? NUM_STAGE_MAX : NUM_STAGE;
    localparam logic SGN_MODE = (DIN0_SIGNED != 0) || (DIN1_SIGNED != 0);
    localparam logic signed [SAT_W-1:0] SAT_HI = sat_limit(DOUT_WIDTH, SGN_MODE, 1'b1);
    localparam logic signed [SAT_W-1:0] SAT_LO = sat_limit(DOUT_WIDTH, SGN_MODE, 1'b0);

    logic                    adv;
    logic                    core_vld;
    logic                    core_last;
    logic                    core_any;
    logic [P_W-1:0]          core_prod;
    logic [ACC_W-1:0]        prod_ext;
    logic [ACC_W-1:0]        sum_w;
    logic signed [SAT_W-1:0] sat_ext;
    logic [DOUT_WIDTH-1:0]   sat_dat;
    logic                    acc_busy;

    assign adv       = !dout_valid || dout_ready;
    assign din_ready = adv;

    filter_mul_pipe_core #(
        .A_W       (DIN0_WIDTH),
        .B_W       (DIN1_WIDTH),
        .A_SIGNED  (DIN0_SIGNED),
        .B_SIGNED  (DIN1_SIGNED),
        .NUM_STAGE (NS)
    ) u_core (
        .core_clk (ap_clk),
        .arst_n   (ap_rst_n),
        .en       (adv),
        .in_vld   (din_valid),
        .in_last  (din_last && (ACC_EN != 0)),
        .a_dat    (din0),
        .b_dat    (din1),
        .out_vld  (core_vld),
        .out_last (core_last),
        .prod_dat (core_prod),
        .any_vld  (core_any)
    );

    assign prod_ext = {{ACC_GUARD{SGN_MODE && core_prod[P_W-1]}}, core_prod};

    always_comb begin
        sat_ext = {{(SAT_W-ACC_W){SGN_MODE && sum_w[ACC_W-1]}}, sum_w};
        sat_dat = sum_w[DOUT_WIDTH-1:0];
        if (SATURATE != 0) begin
            if (sat_ext > SAT_HI)      sat_dat = SAT_HI[DOUT_WIDTH-1:0];
            else if (sat_ext < SAT_LO) sat_dat = SAT_LO[DOUT_WIDTH-1:0];
        end
    end

    if (ACC_EN != 0) begin : g_acc
        logic [ACC_W-1:0]      acc_q;
        logic                  acc_open_q;
        logic                  out_vld_q;
        logic [DOUT_WIDTH-1:0] out_dat_q;

        assign sum_w = acc_q + prod_ext;

        // The closing beat clears the accumulator in the same cycle it
        // emits the sum, so the next group can start immediately.
        always_ff @(posedge ap_clk or negedge ap_rst_n) begin
            if (!ap_rst_n) begin
                acc_q      <= '0;
                acc_open_q <= 1'b0;
                out_vld_q  <= 1'b0;
                out_dat_q  <= '0;
            end else if (adv) begin
                out_vld_q <= core_vld && core_last;
                if (core_vld) begin
                    if (core_last) begin
                        out_dat_q  <= sat_dat;
                        acc_q      <= '0;
                        acc_open_q <= 1'b0;
                    end else begin
                        acc_q      <= sum_w;
                        acc_open_q <= 1'b1;
                    end
                end
            end
        end

        assign dout_valid = out_vld_q;
        assign dout       = out_dat_q;
        assign acc_busy   = acc_open_q;
    end else begin : g_direct
        logic last_unused;

        assign last_unused = core_last;
        assign sum_w       = prod_ext;
        assign dout_valid  = core_vld;
        assign dout        = sat_dat;
        assign acc_busy    = 1'b0;
    end

    assign busy = core_any || dout_valid || acc_busy;

endmodule

// File: tb/tb_filter_mul_pipe.sv
// Bench for filter_mul_pipe: several configurations, directed and random traffic.
// Results are compared against an arithmetic reference model and constants.
module tb_filter_mul_pipe;
    localparam int NI = 6;
    localparam int W0 = 8;
    localparam int W1 = 22;
    localparam int WO = 29;

    function automatic int cfg_ns(int i);
        case (i)
            4:       return 1;
            5:       return 8;
            default: return 3;
        endcase
    endfunction
    function automatic int cfg_s0(int i);  return (i == 2 || i == 5) ? 1 : 0; endfunction
    function automatic int cfg_s1(int i);  return (i == 2) ? 1 : 0;           endfunction
    function automatic int cfg_sat(int i); return (i == 1 || i == 2 || i == 5) ? 1 : 0; endfunction
    function automatic int cfg_acc(int i); return (i == 3) ? 1 : 0;           endfunction

    logic                   ap_clk = 1'b0;
    logic                   ap_rst_n;
    logic [NI-1:0][W0-1:0]  din0;
    logic [NI-1:0][W1-1:0]  din1;
    logic [NI-1:0]          din_last;
    logic [NI-1:0]          din_valid;
    logic [NI-1:0]          din_ready;
    logic [NI-1:0][WO-1:0]  dout;
    logic [NI-1:0]          dout_valid;
    logic [NI-1:0]          dout_ready;
    logic [NI-1:0]          busy;

    always #5 ap_clk = ~ap_clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        filter_mul_pipe #(
            .DIN0_WIDTH  (W0),
            .DIN1_WIDTH  (W1),
            .DOUT_WIDTH  (WO),
            .NUM_STAGE   (cfg_ns(g)),
            .DIN0_SIGNED (cfg_s0(g)),
            .DIN1_SIGNED (cfg_s1(g)),
            .SATURATE    (cfg_sat(g)),
            .ACC_EN      (cfg_acc(g))
        ) u_dut (
            .ap_clk     (ap_clk),
            .ap_rst_n   (ap_rst_n),
            .din0       (din0[g]),
            .din1       (din1[g]),
            .din_last   (din_last[g]),
            .din_valid  (din_valid[g]),
            .din_ready  (din_ready[g]),
            .dout       (dout[g]),
            .dout_valid (dout_valid[g]),
            .dout_ready (dout_ready[g]),
            .busy       (busy[g])
        );
    end

    int              n_chk = 0;
    int              n_pass = 0;
    int              cur = 0;
    int              stall_mode = 0;
    int unsigned     cyc = 0;
    longint          acc_sum = 0;
    logic [WO-1:0]   exp_q[$];
    logic [WO-1:0]   obs_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    endtask

    function automatic longint ref_prod(int inst, logic [W0-1:0] a, logic [W1-1:0] b);
        longint av, bv;
        av = longint'(a);
        bv = longint'(b);
        if (cfg_s0(inst) != 0 && a[W0-1]) av -= longint'(1) << W0;
        if (cfg_s1(inst) != 0 && b[W1-1]) bv -= longint'(1) << W1;
        return av * bv;
    endfunction

    function automatic logic [WO-1:0] ref_out(int inst, longint v);
        longint      hi, lo;
        logic [63:0] bits;
        if (cfg_sat(inst) != 0) begin
            if (cfg_s0(inst) != 0 || cfg_s1(inst) != 0) begin
                hi = (longint'(1) << (WO - 1)) - 1;
                lo = -(longint'(1) << (WO - 1));
            end else begin
                hi = (longint'(1) << WO) - 1;
                lo = 0;
            end
            if (v > hi) v = hi;
            else if (v < lo) v = lo;
        end
        bits = v;
        return bits[WO-1:0];
    endfunction

    function automatic void model_push(logic [W0-1:0] a, logic [W1-1:0] b, logic last);
        longint p;
        p = ref_prod(cur, a, b);
        if (cfg_acc(cur) != 0) begin
            acc_sum += p;
            if (last) begin
                exp_q.push_back(ref_out(cur, acc_sum));
                acc_sum = 0;
            end
        end else begin
            exp_q.push_back(ref_out(cur, p));
        end
    endfunction

    always @(posedge ap_clk) cyc <= cyc + 1;

    // Every valid output cycle is checked against the head of the model queue,
    // which also proves dout holds steady across stalls.
    always @(negedge ap_clk) begin
        if (ap_rst_n && dout_valid[cur]) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out", 64'(exp_q.size()), 64'd1);
            end else begin
                chk("dout", 64'(dout[cur]), 64'(exp_q[0]));
                if (dout_ready[cur]) begin
                    obs_q.push_back(dout[cur]);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        dout_ready = '1;
        forever begin
            @(posedge ap_clk);
            #1;
            case (stall_mode)
                0:       dout_ready[cur] = 1'b1;
                1:       dout_ready[cur] = ~dout_ready[cur];
                default: dout_ready[cur] = ($urandom_range(0, 2) != 0);
            endcase
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, %0d/%0d checks passed so far", n_pass, n_chk);
        $fatal(1);
    end

    task automatic send(input logic [W0-1:0] a, input logic [W1-1:0] b, input logic last);
        bit done;
        done = 0;
        din0[cur] = a;
        din1[cur] = b;
        din_last[cur] = last;
        din_valid[cur] = 1'b1;
        for (int t = 0; t < 100 && !done; t++) begin
            @(negedge ap_clk);
            if (din_ready[cur]) begin
                model_push(a, b, last);
                done = 1;
            end
            @(posedge ap_clk);
            #1;
        end
        din_valid[cur] = 1'b0;
        if (!done) chk("send_accept", 64'(din_ready[cur]), 64'd1);
    endtask

    task automatic drain();
        for (int t = 0; t < 300; t++) begin
            @(negedge ap_clk);
            if (exp_q.size() == 0 && !busy[cur]) break;
        end
        chk("drain_pending", 64'(exp_q.size()), 64'd0);
        chk("drain_busy", 64'(busy[cur]), 64'd0);
        @(posedge ap_clk);
        #1;
    endtask

    task automatic lat_probe(input string tag, input logic [W0-1:0] a, input logic [W1-1:0] b,
                             input logic last, input int exp_lat, input logic [WO-1:0] exp_val);
        int lat;
        lat = 0;
        send(a, b, last);
        for (int t = 1; t <= 20; t++) begin
            @(negedge ap_clk);
            if (dout_valid[cur]) begin
                lat = t;
                break;
            end
        end
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_val"}, 64'(dout[cur]), 64'(exp_val));
        drain();
    endtask

    initial begin
        int unsigned c0;
        int          grp;
        logic        last;
        ap_rst_n  = 1'b0;
        din0      = '0;
        din1      = '0;
        din_last  = '0;
        din_valid = '0;
        repeat (3) @(posedge ap_clk);
        #1;
        chk("rst_dout_valid", 64'(dout_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_din_ready", 64'(din_ready), 64'({NI{1'b1}}));
        chk("rst_dout0", 64'(dout[0]), 64'd0);
        chk("rst_dout3", 64'(dout[3]), 64'd0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;
        chk("post_rst_din_ready", 64'(din_ready), 64'({NI{1'b1}}));

        cur = 0; lat_probe("trunc", 8'd255, 22'd4194303, 1'b0, 3, 29'd532676353);
        cur = 1; lat_probe("sat", 8'd255, 22'd4194303, 1'b0, 3, 29'd536870911);
        cur = 2; lat_probe("signed", 8'hFD, 22'd5, 1'b0, 3, 29'h1FFFFFF1);
        cur = 4; lat_probe("ns1", 8'd3, 22'd7, 1'b1, 1, 29'd21);
        cur = 5; lat_probe("ns8", 8'h80, 22'd3, 1'b0, 8, 29'h1FFFFE80);

        cur = 3;
        send(8'd2, 22'd3, 1'b0);
        send(8'd4, 22'd5, 1'b0);
        lat_probe("acc", 8'd1, 22'd7, 1'b1, 4, 29'd33);

        obs_q.delete();
        send(8'd2, 22'd3, 1'b0);
        send(8'd4, 22'd5, 1'b0);
        send(8'd1, 22'd7, 1'b1);
        send(8'd10, 22'd10, 1'b1);
        drain();
        chk("acc_pulses", 64'(obs_q.size()), 64'd2);
        if (obs_q.size() == 2) begin
            chk("acc_grp0", 64'(obs_q[0]), 64'd33);
            chk("acc_grp1", 64'(obs_q[1]), 64'd100);
        end

        send(8'd2, 22'd3, 1'b0);
        send(8'd4, 22'd5, 1'b0);
        send(8'd1, 22'd1, 1'b0);
        send(8'd1, 22'd1, 1'b0);
        send(8'd1, 22'd1, 1'b0);
        ap_rst_n = 1'b0;
        #1;
        chk("midrst_dout_valid", 64'(dout_valid[3]), 64'd0);
        chk("midrst_busy", 64'(busy[3]), 64'd0);
        chk("midrst_din_ready", 64'(din_ready[3]), 64'd1);
        exp_q.delete();
        acc_sum = 0;
        repeat (2) @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;
        lat_probe("acc_after_rst", 8'd1, 22'd1, 1'b1, 4, 29'd1);

        cur = 0;
        obs_q.delete();
        stall_mode = 1;
        for (int i = 0; i < 20; i++) send(W0'($urandom), W1'($urandom), 1'b0);
        stall_mode = 0;
        drain();
        chk("stream_count", 64'(obs_q.size()), 64'd20);

        c0 = cyc;
        for (int i = 0; i < 10; i++) send(W0'($urandom), W1'($urandom), 1'b0);
        chk("throughput_cycles", 64'(cyc - c0), 64'd10);
        drain();

        for (int inst = 0; inst < NI; inst++) begin
            cur = inst;
            stall_mode = 2;
            grp = 0;
            for (int i = 0; i < 40; i++) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge ap_clk);
                    #1;
                end
                last = (grp == 5) || (i == 39) || ($urandom_range(0, 2) == 0);
                grp = last ? 0 : grp + 1;
                send(W0'($urandom), W1'($urandom), last);
            end
            stall_mode = 0;
            drain();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/filter_mul_pipe.md
FILTER_MUL_PIPE -- requirements
Module: filter_mul_pipe

Interface
REQ-001 SHALL have parameter DIN0_WIDTH, default 8, operand A width (2..32).
REQ-002 SHALL have parameter DIN1_WIDTH, default 22, operand B width (2..32).
REQ-003 SHALL have parameter DOUT_WIDTH, default 29, result width (1..DIN0_WIDTH+DIN1_WIDTH).
REQ-004 SHALL have parameter NUM_STAGE, default 3, pipeline latency in cycles (1..8).
REQ-005 SHALL have parameter DIN0_SIGNED / DIN1_SIGNED, default 0 / 0, per-operand two's-complement mode.
REQ-006 SHALL have parameter SATURATE, default 0; 0 truncates to DOUT_WIDTH LSBs, 1 clamps to DOUT_WIDTH range.
REQ-007 SHALL have parameter ACC_EN, default 0; 1 enables multiply-accumulate mode.
REQ-008 SHALL have port ap_clk, input, 1, sole clock, all state on rising edge.
REQ-009 SHALL have port ap_rst_n, input, 1, reset; asynchronous, active-low.
REQ-010 SHALL have ports din0 (input, DIN0_WIDTH), din1 (input, DIN1_WIDTH), operands.
REQ-011 SHALL have port din_last, input, 1, final beat of an accumulation group (ignored when ACC_EN=0).
REQ-012 SHALL have ports din_valid (input, 1), din_ready (output, 1), input handshake.
REQ-013 SHALL have ports dout (output, DOUT_WIDTH), dout_valid (output, 1), dout_ready (input, 1), output handshake.
REQ-014 SHALL have port busy, output, 1, high when any pipeline stage or accumulator holds data.

Function
REQ-015 Beat accepted SHALL be defined as din_valid && din_ready on a rising edge; output transfer as dout_valid && dout_ready.
REQ-016 Pipeline SHALL advance (adv) when !dout_valid || dout_ready; din_ready SHALL equal adv (combinational, no dependency on din_valid).
REQ-017 When adv=0, all stage registers and valid bits SHALL hold; no beat lost or duplicated.
REQ-018 Full product SHALL be computed at width DIN0_WIDTH+DIN1_WIDTH, each operand sign- or zero-extended per its SIGNED parameter.
REQ-019 With ACC_EN=0, an accepted beat SHALL appear on dout with dout_valid exactly NUM_STAGE cycles later, absent stalls.
REQ-020 SATURATE=0: dout SHALL be product[DOUT_WIDTH-1:0]; SATURATE=1: dout SHALL clamp to max/min of DOUT_WIDTH (signed range if either operand signed, else unsigned).
REQ-021 ACC_EN=1: products SHALL sum into an accumulator of width DIN0_WIDTH+DIN1_WIDTH+8, wrapping modulo 2^width; dout_valid asserts once per group, NUM_STAGE+1 cycles after the din_last beat, carrying the saturated/truncated sum; accumulator clears for the next group in the same cycle, so back-to-back groups lose no beats.
REQ-022 ACC_EN=1: non-last beats SHALL NOT produce dout_valid.
REQ-023 Back-to-back accepted beats with dout_ready=1 SHALL sustain throughput of one result per cycle (ACC_EN=0).
REQ-024 dout SHALL be stable while dout_valid=1 and dout_ready=0.
REQ-025 busy SHALL be the OR of all stage valid bits, dout_valid and (ACC_EN) accumulator-open flag.

Reset
REQ-026 On ap_rst_n low, all valid bits, accumulator, accumulator-open flag SHALL clear asynchronously; dout_valid=0, busy=0, dout=0.
REQ-027 din_ready SHALL be 1 during and immediately after reset.
REQ-028 Reset mid-operation SHALL discard all in-flight beats and partial sums; first beat after release is a fresh group.
REQ-029 Reset release SHALL take effect synchronously to ap_clk; no beat accepted in the release cycle when ap_rst_n is low at the edge.

Structure
REQ-030 Shared package filter_mul_pkg SHALL hold the accumulator guard width (8), NUM_STAGE limits, and the saturation-limit function.
REQ-031 Multiply core SHALL be one sub-module filter_mul_pipe_core (registered product stages with enable); handshake, accumulate and saturation live in the top.

Verification
REQ-032 Defaults, din0=255, din1=4194303, dout_ready=1 -> dout=532676353 at cycle +3; SATURATE=1 -> 536870911.
REQ-033 DIN0_SIGNED=1, DIN1_SIGNED=1, DOUT_WIDTH=29, din0=8'hFD (-3), din1=5 -> dout = -15 (29'h1FFFFFF1).
REQ-034 Stream 20 beats, dout_ready toggling 1/0 each cycle -> 20 results, in order, none dropped/duplicated, dout stable while stalled.
REQ-035 ACC_EN=1, group (2x3, 4x5, 1x7 last) then group (10x10 last) back-to-back -> dout 33 then 100, exactly two dout_valid pulses.
REQ-036 Assert ap_rst_n low with 3 beats in flight and partial sum 26 -> dout_valid=0, busy=0 immediately; next group (1x1 last) -> dout 1.
REQ-037 NUM_STAGE=1 and NUM_STAGE=8, random operands, random stalls -> results match scoreboard with latency NUM_STAGE.
